// File: rtl/txn_copy_dma.sv
// ---------------------------------------------------------------------------
// txn_copy_dma
//   Word-copy DMA initiator on the txn_* transaction bus. A start command
//   written through ctrl_in copies LEN 32-bit words from the source window
//   to the destination window. Each word is one read followed by one write.
//   On completion the block sets done and pulses int_done if int_en is set.
//
// Ports
//   clk        clock, all logic on posedge
//   srst       synchronous reset, active high
//   ctrl_wr    ctrl_in write strobe
//   ctrl_in    [31]=start [30]=int_en [29:20]=len [19:10]=src_off [9:0]=dst_off
//   ctrl_out   [31]=busy [30]=done [29]=err [28:10]=0 [9:0]=words remaining
//   txn_req    transaction request, gated combinationally by txn_rdy
//   txn_wr     1=write, 0=read (registered, valid with txn_req)
//   txn_addr   word-aligned byte address (registered)
//   txn_wdata  write data (registered; holds the word just read)
//   txn_rdata  read data, valid when txn_rdy rises after a read
//   txn_rdy    responder ready / transaction complete
//   int_done   one-cycle completion pulse, gated by int_en
//
// Optional feature macro: TXN_DMA_TIMEOUT_EN
//   When defined, a per-state wait counter aborts a transfer after TIMEOUT
//   stalled cycles and sets err and done. When undefined, the block waits
//   indefinitely and ctrl_out[29] reads 0.
// ---------------------------------------------------------------------------
module txn_copy_dma #(
  parameter logic [31:0] SRC_BASE = 32'h4000_0000,
  parameter logic [31:0] DST_BASE = 32'h4000_2000,
  parameter int          LEN_W    = 10,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        ctrl_wr,
  input  logic [31:0] ctrl_in,
  output logic [31:0] ctrl_out,
  output logic        txn_req,
  output logic        txn_wr,
  output logic [31:0] txn_addr,
  output logic [31:0] txn_wdata,
  input  logic [31:0] txn_rdata,
  input  logic        txn_rdy,
  output logic        int_done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic             int_en;
  logic             done;
  logic             err;
  logic             wait_first;
  logic             advance;
  logic             start;
  logic [LEN_W-1:0] start_len;
  logic [31:0]      start_src;
  logic [31:0]      start_dst;

  assign start     = ctrl_wr && ctrl_in[31];
  assign start_len = LEN_W'(ctrl_in[29:20]);
  assign start_src = SRC_BASE + {20'd0, ctrl_in[19:10], 2'b00};
  assign start_dst = DST_BASE + {20'd0, ctrl_in[9:0], 2'b00};

  // The request is gated by txn_rdy so nothing is issued while the
  // responder is still busy with a previous transaction.
  assign txn_req  = ((state == RD_REQ) || (state == WR_REQ)) && txn_rdy;
  assign ctrl_out = {(state != IDLE), done, err, 19'd0, 10'(remaining)};

  // advance marks the edges on which the FSM leaves a REQ or WAIT state.
  // The cycle right after an issue edge (wait_first) never completes a
  // transaction, even if the responder still shows txn_rdy high.
  always_comb begin
    advance = 1'b0;
    case (state)
      RD_REQ, WR_REQ:   advance = txn_rdy;
      RD_WAIT, WR_WAIT: advance = txn_rdy && !wait_first;
      default:          advance = 1'b0;
    endcase
  end

`ifdef TXN_DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      remaining  <= '0;
      src_addr   <= '0;
      dst_addr   <= '0;
      int_en     <= 1'b0;
      done       <= 1'b0;
      wait_first <= 1'b0;
      txn_wr     <= 1'b0;
      txn_addr   <= '0;
      txn_wdata  <= '0;
      int_done   <= 1'b0;
`ifdef TXN_DMA_TIMEOUT_EN
      err        <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      int_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            int_en    <= ctrl_in[30];
            done      <= 1'b0;
            remaining <= start_len;
            src_addr  <= start_src;
            dst_addr  <= start_dst;
`ifdef TXN_DMA_TIMEOUT_EN
            err       <= 1'b0;
`endif
            if (start_len == '0) begin
              // Zero-length copy completes at once; the !int_done term
              // keeps back-to-back completions from merging into a
              // two-cycle pulse.
              done     <= 1'b1;
              int_done <= ctrl_in[30] && !int_done;
            end else begin
              state    <= RD_REQ;
              txn_wr   <= 1'b0;
              txn_addr <= start_src;
            end
          end
        end

        RD_REQ: begin
          if (advance) begin
            state      <= RD_WAIT;
            wait_first <= 1'b1;
          end
        end

        RD_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            txn_wdata <= txn_rdata;
            txn_wr    <= 1'b1;
            txn_addr  <= dst_addr;
            state     <= WR_REQ;
          end
        end

        WR_REQ: begin
          if (advance) begin
            state      <= WR_WAIT;
            wait_first <= 1'b1;
          end
        end

        WR_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state    <= IDLE;
              done     <= 1'b1;
              int_done <= int_en;
            end else begin
              src_addr <= src_addr + 32'd4;
              dst_addr <= dst_addr + 32'd4;
              txn_addr <= src_addr + 32'd4;
              txn_wr   <= 1'b0;
              state    <= RD_REQ;
            end
          end
        end

        default: state <= IDLE;
      endcase

`ifdef TXN_DMA_TIMEOUT_EN
      // Counts every cycle spent stalled in a busy state; any state change
      // restarts the count. The abort overrides whatever the case above chose.
      if ((state == IDLE) || advance) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
        tmo_cnt  <= '0;
        state    <= IDLE;
        done     <= 1'b1;
        err      <= 1'b1;
        int_done <= int_en;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_txn_copy_dma.sv
// ---------------------------------------------------------------------------
// tb_txn_copy_dma
//   Self-checking bench for txn_copy_dma. A 1-wait responder backs a flat
//   memory (chip0 at 0x40000000, chip1 at 0x40002000) and logs every issued
//   transaction. Expected transaction streams, cycle counts and status words
//   are computed from the copy rules: word i reads SRC_BASE+4*(src+i), then
//   writes the same data to DST_BASE+4*(dst+i), and each word takes 6 cycles.
// ---------------------------------------------------------------------------
module tb_txn_copy_dma;

  localparam logic [31:0] SRC_BASE = 32'h4000_0000;
  localparam logic [31:0] DST_BASE = 32'h4000_2000;
  localparam int          MEM_N    = 4096;

  logic        clk = 1'b0;
  logic        srst;
  logic        ctrl_wr;
  logic [31:0] ctrl_in;
  logic [31:0] ctrl_out;
  logic        txn_req;
  logic        txn_wr;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic [31:0] txn_rdata;
  logic        txn_rdy;
  logic        int_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem      [0:MEM_N-1];
  logic        log_wr   [0:MEM_N-1];
  logic [31:0] log_addr [0:MEM_N-1];
  logic [31:0] log_data [0:MEM_N-1];
  int          log_n;
  logic        pending;
  logic        stall;
  logic [31:0] rd_val;

  txn_copy_dma dut (
    .clk       (clk),
    .srst      (srst),
    .ctrl_wr   (ctrl_wr),
    .ctrl_in   (ctrl_in),
    .ctrl_out  (ctrl_out),
    .txn_req   (txn_req),
    .txn_wr    (txn_wr),
    .txn_addr  (txn_addr),
    .txn_wdata (txn_wdata),
    .txn_rdata (txn_rdata),
    .txn_rdy   (txn_rdy),
    .int_done  (int_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - SRC_BASE) >> 2;
    if (idx < MEM_N) return mem[idx[11:0]];
    return 32'hDEAD_BEEF;
  endfunction

  // 1-wait responder: drops txn_rdy on the issue edge and raises it with
  // the read data one edge later. While stall is set it never completes.
  always @(posedge clk) begin
    if (srst) begin
      txn_rdy   <= 1'b1;
      pending   <= 1'b0;
      txn_rdata <= '0;
      rd_val    <= '0;
    end else if (pending) begin
      txn_rdy   <= 1'b1;
      pending   <= 1'b0;
      txn_rdata <= rd_val;
    end else if (txn_req && txn_rdy) begin
      txn_rdy <= 1'b0;
      pending <= !stall;
      rd_val  <= memRead(txn_addr);
      if (log_n < MEM_N) begin
        log_wr[log_n]   <= txn_wr;
        log_addr[log_n] <= txn_addr;
        log_data[log_n] <= txn_wdata;
      end
      log_n <= log_n + 1;
    end else if (!txn_rdy && !stall) begin
      txn_rdy   <= 1'b1;
      txn_rdata <= rd_val;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares the logged transactions since base with the copy model.
  task automatic checkLog(input int base, input int len, input int src, input int dst);
    int pairs;
    int r;
    checkOutput("txn_count", log_n - base, 2 * len);
    pairs = (log_n - base) / 2;
    if (pairs > len) pairs = len;
    for (int i = 0; i < pairs; i++) begin
      r = base + 2 * i;
      if (r + 1 < MEM_N) begin
        checkOutput("rd_kind", 32'(log_wr[r]), 32'd0);
        checkOutput("rd_addr", log_addr[r], SRC_BASE + 32'(4 * (src + i)));
        checkOutput("wr_kind", 32'(log_wr[r+1]), 32'd1);
        checkOutput("wr_addr", log_addr[r+1], DST_BASE + 32'(4 * (dst + i)));
        checkOutput("wr_data", log_data[r+1], mem[src + i]);
      end
    end
  endtask

  // Starts a copy and follows it to completion. poke >= 0 fires a second
  // start command that many cycles in, which the busy DMA must ignore.
  task automatic applyStimulus(input int len, input int src, input int dst,
                               input bit ien, input int poke);
    int k;
    int pulses;
    int first;
    int base;
    bit prev;
    bit consec;
    base    = log_n;
    ctrl_in = {1'b1, ien, 10'(len), 10'(src), 10'(dst)};
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    k = 0; pulses = 0; first = -1; prev = 1'b0; consec = 1'b0;
    forever begin
      if (int_done) begin
        pulses++;
        if (first < 0) first = k;
        if (prev) consec = 1'b1;
      end
      prev = int_done;
      if (k > 0 && k % 6 == 0 && ctrl_out[31])
        checkOutput("remaining", ctrl_out, {1'b1, 2'b00, 19'd0, 10'(len - k / 6)});
      if (!ctrl_out[31] || k > 6 * len + 40) break;
      if (k == poke) begin
        ctrl_in = {1'b1, 1'b1, 10'd1, 10'd900, 10'd900};
        ctrl_wr = 1'b1;
      end
      tick();
      ctrl_wr = 1'b0;
      k++;
    end
    checkOutput("cycles", k, 6 * len);
    checkOutput("int_count", pulses, ien ? 1 : 0);
    if (ien) checkOutput("int_cycle", first, 6 * len);
    checkOutput("status", ctrl_out, 32'h4000_0000);
    tick();
    checkOutput("int_clear", 32'(int_done), 32'd0);
    checkOutput("int_consec", 32'(consec), 32'd0);
    checkLog(base, len, src, dst);
  endtask

  initial begin
    int base;
    int k;
    int pulses;
    srst    = 1'b1;
    ctrl_wr = 1'b0;
    ctrl_in = '0;
    stall   = 1'b0;
    for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
    repeat (3) tick();

    checkOutput("rst_ctrl_out", ctrl_out, 32'd0);
    checkOutput("rst_txn_req", 32'(txn_req), 32'd0);
    checkOutput("rst_txn_wr", 32'(txn_wr), 32'd0);
    checkOutput("rst_txn_addr", txn_addr, 32'd0);
    checkOutput("rst_txn_wdata", txn_wdata, 32'd0);
    checkOutput("rst_int_done", 32'(int_done), 32'd0);
    srst = 1'b0;
    tick();

    $display("[TB] T1 len=4 copy");
    applyStimulus(4, 0, 0, 1'b1, -1);

    $display("[TB] ctrl_wr without start bit");
    base    = log_n;
    ctrl_in = {1'b0, 1'b1, 10'd5, 10'd1, 10'd1};
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    tick();
    checkOutput("nostart_status", ctrl_out, 32'h4000_0000);
    checkOutput("nostart_txns", log_n - base, 0);

    $display("[TB] T2 len=0");
    applyStimulus(0, 3, 3, 1'b1, -1);

    $display("[TB] T3 len=3 src=5 dst=120");
    applyStimulus(3, 5, 120, 1'b0, -1);

    $display("[TB] T4 start while busy");
    applyStimulus(8, 200, 300, 1'b1, 10);

    $display("[TB] T5 srst mid-transfer");
    ctrl_in = {1'b1, 1'b1, 10'd5, 10'd7, 10'd9};
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    repeat (7) tick();
    checkOutput("t5_busy", ctrl_out, {1'b1, 2'b00, 19'd0, 10'd4});
    srst = 1'b1;
    tick();
    checkOutput("t5_txn_req", 32'(txn_req), 32'd0);
    checkOutput("t5_ctrl_out", ctrl_out, 32'd0);
    checkOutput("t5_int_done", 32'(int_done), 32'd0);
    srst = 1'b0;
    tick();
    applyStimulus(2, 30, 40, 1'b1, -1);

    $display("[TB] random copies");
    for (int t = 0; t < 6; t++)
      applyStimulus(int'($urandom_range(1, 12)), int'($urandom_range(0, 1000)),
                    int'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)), -1);

`ifdef TXN_DMA_TIMEOUT_EN
    $display("[TB] T6 timeout");
    stall   = 1'b1;
    base    = log_n;
    ctrl_in = {1'b1, 1'b1, 10'd3, 10'd50, 10'd60};
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    k = 0; pulses = 0;
    while (ctrl_out[31] && k < 200) begin
      tick();
      k++;
      if (int_done) pulses++;
    end
    checkOutput("tmo_cycles", k, 65);
    checkOutput("tmo_status", ctrl_out, {1'b0, 1'b1, 1'b1, 19'd0, 10'd3});
    checkOutput("tmo_int", pulses, 1);
    checkOutput("tmo_txns", log_n - base, 1);
    stall = 1'b0;
    repeat (3) tick();
`else
    $display("[TB] stalled responder");
    stall   = 1'b1;
    base    = log_n;
    ctrl_in = {1'b1, 1'b1, 10'd2, 10'd11, 10'd22};
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    repeat (150) tick();
    checkOutput("stall_status", ctrl_out, {1'b1, 2'b00, 19'd0, 10'd2});
    checkOutput("stall_txns", log_n - base, 1);
    stall = 1'b0;
    k = 0;
    while (ctrl_out[31] && k < 100) begin
      tick();
      k++;
    end
    checkOutput("stall_done", ctrl_out, 32'h4000_0000);
    checkLog(base, 2, 11, 22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
